// File: rtl/i2c_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_regbank_pkg
// Purpose  : Fixed command addresses and address-map helpers for the I2C bank.
// Revision : 1.0
// ============================================================================
package i2c_regbank_pkg;

    localparam logic [7:0] c_ADDR_PAGE      = 8'h80;
    localparam logic [7:0] c_ADDR_RESET_DC  = 8'hF0;
    localparam logic [7:0] c_ADDR_RESET_OPT = 8'hF1;
    localparam logic [7:0] c_ADDR_CLEAR     = 8'hF2;

    localparam int c_OSD_PAGE_LEN = 129;    // OSD window 00..7F plus page register 80
    localparam int c_CMD_BASE     = 'hF0;
    localparam int c_CMD_LEN      = 3;

    function automatic logic addr_in_range(input logic [7:0] a, input int base, input int len);
        return (int'(a) >= base) && (int'(a) < base + len);
    endfunction

    function automatic logic regions_overlap(input int a_base, input int a_len,
                                             input int b_base, input int b_len);
        return (a_base < b_base + b_len) && (b_base < a_base + a_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_edge_strobe.sv
`default_nettype none
// ============================================================================
// Module   : i2c_edge_strobe
// Purpose  : Rising-edge detect on the write qualifier and one-cycle pulses.
// Revision : 1.0
// ============================================================================
module i2c_edge_strobe #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_req,
    output logic             o_we_edge,
    output logic [WIDTH-1:0] o_pulse
);

    logic             r_we_d;
    logic [WIDTH-1:0] r_pulse;
    logic             w_edge;

    assign w_edge = i_we & ~r_we_d;

    // Requests only latch on the edge; the pulse self-clears the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we_d  <= 1'b0;
            r_pulse <= '0;
        end else begin
            r_we_d  <= i_we;
            r_pulse <= w_edge ? i_req : '0;
        end
    end

    assign o_we_edge = w_edge;
    assign o_pulse   = r_pulse;

endmodule
`default_nettype wire

// File: rtl/i2c_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : i2c_register_bank
// Purpose  : Parametrised I2C register map: OSD RAM window, control registers,
//            snapshot-read counters, status word and command pulses.
// Revision : 1.0
// ============================================================================
module i2c_register_bank
    import i2c_regbank_pkg::*;
#(
    parameter int                    NUM_CTRL     = 16,
    parameter int                    CTRL_BASE    = 'h90,
    parameter logic [NUM_CTRL*8-1:0] CTRL_RESET   = '0,
    parameter int                    NUM_COUNTERS = 6,
    parameter int                    COUNTER_W    = 32,
    parameter int                    COUNTER_BASE = 'hA0,
    parameter int                    STATUS_W     = 24,
    parameter int                    STATUS_BASE  = 'hC0,
    parameter int                    PAGE_BITS    = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [7:0]                        addr,
    input  logic [7:0]                        dataIn,
    input  logic                              writeEn,
    input  logic                              readEn,
    output logic [7:0]                        dataOut,
    output logic [7:0]                        ram_dataIn,
    output logic [PAGE_BITS+6:0]              ram_wraddress,
    output logic                              ram_wren,
    output logic [NUM_CTRL*8-1:0]             ctrl_regs,
    output logic [NUM_CTRL-1:0]               ctrl_changed,
    output logic                              reset_dc,
    output logic                              reset_opt,
    output logic [NUM_COUNTERS-1:0]           counter_clear,
    input  logic [NUM_COUNTERS*COUNTER_W-1:0] counters_in,
    input  logic [STATUS_W-1:0]               status_in
);

    localparam int c_B       = COUNTER_W / 8;
    localparam int c_S       = STATUS_W / 8;
    localparam int c_CNT_LEN = NUM_COUNTERS * c_B;
    localparam int c_IDXW    = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
    localparam int c_PW      = NUM_CTRL + 2 + NUM_COUNTERS;

    localparam bit c_MAP_BAD =
        regions_overlap(CTRL_BASE, NUM_CTRL, 0, c_OSD_PAGE_LEN) ||
        regions_overlap(CTRL_BASE, NUM_CTRL, c_CMD_BASE, c_CMD_LEN) ||
        regions_overlap(COUNTER_BASE, c_CNT_LEN, 0, c_OSD_PAGE_LEN) ||
        regions_overlap(COUNTER_BASE, c_CNT_LEN, c_CMD_BASE, c_CMD_LEN) ||
        regions_overlap(STATUS_BASE, c_S, 0, c_OSD_PAGE_LEN) ||
        regions_overlap(STATUS_BASE, c_S, c_CMD_BASE, c_CMD_LEN) ||
        regions_overlap(CTRL_BASE, NUM_CTRL, COUNTER_BASE, c_CNT_LEN) ||
        regions_overlap(CTRL_BASE, NUM_CTRL, STATUS_BASE, c_S) ||
        regions_overlap(COUNTER_BASE, c_CNT_LEN, STATUS_BASE, c_S) ||
        (CTRL_BASE + NUM_CTRL > 256) || (COUNTER_BASE + c_CNT_LEN > 256) ||
        (STATUS_BASE + c_S > 256);

    localparam bit c_PARAM_BAD = (COUNTER_W % 8 != 0) || (COUNTER_W < 8) || (COUNTER_W > 32) ||
                                 (STATUS_W % 8 != 0) || (STATUS_W < 8) || (PAGE_BITS < 1);

    generate
        if (c_MAP_BAD) begin : g_map_check
            $error("i2c_register_bank: address regions overlap or exceed 8-bit space");
        end
        if (c_PARAM_BAD) begin : g_param_check
            $error("i2c_register_bank: illegal counter/status/page width");
        end
    endgenerate

    logic [PAGE_BITS-1:0]      r_page;
    logic                      r_ram_wren;
    logic [PAGE_BITS+6:0]      r_ram_addr;
    logic [7:0]                r_ram_data;
    logic [NUM_CTRL*8-1:0]     r_ctrl;
    logic [COUNTER_W-1:0]      r_snap;
    logic [c_IDXW-1:0]         r_snap_idx;
    logic [7:0]                r_dout;

    logic                      w_we_edge;
    logic [NUM_CTRL-1:0]       w_ctrl_hit;
    logic [NUM_COUNTERS-1:0]   w_clear_req;
    logic [c_PW-1:0]           w_req;
    logic [c_PW-1:0]           w_pulse;
    logic                      w_cnt_hit;
    int                        w_cnt_k;
    int                        w_cnt_j;
    logic [7:0]                w_rd_data;

    always_comb begin
        w_ctrl_hit  = '0;
        w_clear_req = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            w_ctrl_hit[i] = (int'(addr) == CTRL_BASE + i);
        end
        // Clear mask bits beyond the byte width simply never fire.
        if (addr == c_ADDR_CLEAR) begin
            for (int b = 0; b < NUM_COUNTERS; b++) begin
                w_clear_req[b] = (b < 8) ? dataIn[b[2:0]] : 1'b0;
            end
        end
    end

    assign w_req = {w_clear_req, (addr == c_ADDR_RESET_OPT), (addr == c_ADDR_RESET_DC), w_ctrl_hit};

    i2c_edge_strobe #(
        .WIDTH (c_PW)
    ) u_strobe (
        .clk       (clk),
        .rst       (reset),
        .i_we      (writeEn),
        .i_req     (w_req),
        .o_we_edge (w_we_edge),
        .o_pulse   (w_pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_page     <= '0;
            r_ram_wren <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ctrl     <= CTRL_RESET;
        end else begin
            r_ram_wren <= 1'b0;
            if (w_we_edge && !addr[7]) begin
                r_ram_wren <= 1'b1;
                r_ram_addr <= {r_page, addr[6:0]};
                r_ram_data <= dataIn;
            end
            if (w_we_edge && addr == c_ADDR_PAGE) begin
                r_page <= dataIn[PAGE_BITS-1:0];
            end
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (w_we_edge && w_ctrl_hit[i]) begin
                    r_ctrl[i*8 +: 8] <= dataIn;
                end
            end
        end
    end

    always_comb begin
        w_cnt_hit = addr_in_range(addr, COUNTER_BASE, c_CNT_LEN);
        w_cnt_k   = 0;
        w_cnt_j   = 0;
        if (w_cnt_hit) begin
            w_cnt_k = (int'(addr) - COUNTER_BASE) / c_B;
            w_cnt_j = (int'(addr) - COUNTER_BASE) % c_B;
        end
    end

    // Reading a counter MSB freezes the rest of that counter for the following byte reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap     <= '0;
            r_snap_idx <= '0;
        end else if (readEn && w_cnt_hit && w_cnt_j == 0) begin
            r_snap     <= counters_in[w_cnt_k*COUNTER_W +: COUNTER_W];
            r_snap_idx <= w_cnt_k[c_IDXW-1:0];
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        if (addr == c_ADDR_PAGE) begin
            w_rd_data = 8'(r_page);
        end else if (addr_in_range(addr, CTRL_BASE, NUM_CTRL)) begin
            w_rd_data = r_ctrl[(int'(addr) - CTRL_BASE)*8 +: 8];
        end else if (w_cnt_hit) begin
            if (w_cnt_j != 0 && w_cnt_k == int'(r_snap_idx)) begin
                w_rd_data = r_snap[(c_B-1-w_cnt_j)*8 +: 8];
            end else begin
                w_rd_data = counters_in[w_cnt_k*COUNTER_W + (c_B-1-w_cnt_j)*8 +: 8];
            end
        end else if (addr_in_range(addr, STATUS_BASE, c_S)) begin
            w_rd_data = status_in[(c_S-1-(int'(addr) - STATUS_BASE))*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= 8'h00;
        end else begin
            r_dout <= w_rd_data;
        end
    end

    assign dataOut       = r_dout;
    assign ram_dataIn    = r_ram_data;
    assign ram_wraddress = r_ram_addr;
    assign ram_wren      = r_ram_wren;
    assign ctrl_regs     = r_ctrl;
    assign ctrl_changed  = w_pulse[NUM_CTRL-1:0];
    assign reset_dc      = w_pulse[NUM_CTRL];
    assign reset_opt     = w_pulse[NUM_CTRL+1];
    assign counter_clear = w_pulse[NUM_CTRL+2 +: NUM_COUNTERS];

endmodule
`default_nettype wire

// File: tb/tb_i2c_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_register_bank
// Purpose  : Scoreboard bench for i2c_register_bank (default map, CTRL_RESET=0503).
// Revision : 1.0
// ============================================================================
module tb_i2c_register_bank;

    typedef struct packed {
        logic        wren;
        logic [9:0]  wa;
        logic [7:0]  wd;
        logic [15:0] cc;
        logic        dc;
        logic        opt;
        logic [5:0]  clr;
    } ev_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } rd_t;

    logic         clk;
    logic         reset;
    logic [7:0]   addr;
    logic [7:0]   dataIn;
    logic         writeEn;
    logic         readEn;
    logic [7:0]   dataOut;
    logic [7:0]   ram_dataIn;
    logic [9:0]   ram_wraddress;
    logic         ram_wren;
    logic [127:0] ctrl_regs;
    logic [15:0]  ctrl_changed;
    logic         reset_dc;
    logic         reset_opt;
    logic [5:0]   counter_clear;
    logic [191:0] counters_in;
    logic [23:0]  status_in;

    logic         rd_chk;
    ev_t          ev_q[$];
    rd_t          rd_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    i2c_register_bank #(
        .CTRL_RESET (128'h0503)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .addr          (addr),
        .dataIn        (dataIn),
        .writeEn       (writeEn),
        .readEn        (readEn),
        .dataOut       (dataOut),
        .ram_dataIn    (ram_dataIn),
        .ram_wraddress (ram_wraddress),
        .ram_wren      (ram_wren),
        .ctrl_regs     (ctrl_regs),
        .ctrl_changed  (ctrl_changed),
        .reset_dc      (reset_dc),
        .reset_opt     (reset_opt),
        .counter_clear (counter_clear),
        .counters_in   (counters_in),
        .status_in     (status_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(input logic wren, input logic [9:0] wa, input logic [7:0] wd,
                                  input logic [15:0] cc, input logic dc, input logic opt,
                                  input logic [5:0] clr);
        ev_t e;
        e.wren = wren; e.wa = wa; e.wd = wd; e.cc = cc; e.dc = dc; e.opt = opt; e.clr = clr;
        return e;
    endfunction

    // Any pulse activity must match the next expected event; a stray or stretched pulse has none.
    always @(negedge clk) begin
        ev_t act;
        ev_t exp;
        rd_t r;
        if ((ram_wren | reset_dc | reset_opt | (|ctrl_changed) | (|counter_clear)) === 1'b1) begin
            act = mk_ev(ram_wren, ram_wraddress, ram_dataIn, ctrl_changed, reset_dc, reset_opt, counter_clear);
            if (ev_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: got %0h expected no pulse", act);
            end else begin
                exp = ev_q.pop_front();
                if (!exp.wren) begin
                    act.wa = '0; act.wd = '0;
                end
                check("pulse_event", act, exp);
            end
        end
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL read_queue: got empty queue expected an entry");
            end else begin
                r = rd_q.pop_front();
                check($sformatf("read_%02h", r.a), dataOut, r.d);
            end
        end
    end

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold);
        addr    = a;
        dataIn  = d;
        writeEn = 1'b1;
        repeat (hold) @(posedge clk);
        #1 writeEn = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input logic re);
        rd_t r;
        r.a = a;
        r.d = exp;
        rd_q.push_back(r);
        addr   = a;
        readEn = re;
        @(posedge clk);
        #1 readEn = 1'b0;
        rd_chk = 1'b1;
        @(posedge clk);
        #1 rd_chk = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        writeEn = 1'b0;
        readEn  = 1'b0;
        addr    = 8'h00;
        dataIn  = 8'h00;
        rd_chk  = 1'b0;
        counters_in = '0;
        counters_in[32 +: 32] = 32'h11223344;
        counters_in[64 +: 32] = 32'hCAFEBABE;
        status_in = 24'h123456;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl_regs", ctrl_regs, 128'h0503);
        check("rst_dataOut", dataOut, 8'h00);
        check("rst_ram_wren", ram_wren, 1'b0);
        check("rst_ram_wraddress", ram_wraddress, 10'h000);
        check("rst_ctrl_changed", ctrl_changed, 16'h0000);
        check("rst_cmd_pulses", {reset_dc, reset_opt, counter_clear}, 8'h00);
        @(posedge clk);
        #1 reset = 1'b0;

        do_write(8'h80, 8'h02, 1);
        ev_q.push_back(mk_ev(1'b1, 10'h115, 8'hAA, 16'h0, 1'b0, 1'b0, 6'h0));
        do_write(8'h15, 8'hAA, 4);
        do_read(8'h80, 8'h02, 1'b0);

        ev_q.push_back(mk_ev(1'b0, 10'h0, 8'h0, 16'h0008, 1'b0, 1'b0, 6'h0));
        do_write(8'h93, 8'h7F, 1);
        do_read(8'h93, 8'h7F, 1'b0);
        ev_q.push_back(mk_ev(1'b0, 10'h0, 8'h0, 16'h0008, 1'b0, 1'b0, 6'h0));
        do_write(8'h93, 8'h7F, 2);
        do_read(8'h90, 8'h03, 1'b0);
        do_read(8'h91, 8'h05, 1'b0);

        do_read(8'hA4, 8'h11, 1'b1);
        counters_in[32 +: 32] = 32'h55667788;
        do_read(8'hA5, 8'h22, 1'b0);
        do_read(8'hA6, 8'h33, 1'b0);
        do_read(8'hA7, 8'h44, 1'b0);
        do_read(8'hA4, 8'h55, 1'b0);
        do_read(8'hA9, 8'hFE, 1'b0);

        do_read(8'hC0, 8'h12, 1'b0);
        do_read(8'hC2, 8'h56, 1'b0);
        do_read(8'h85, 8'h00, 1'b0);
        do_write(8'hC0, 8'hFF, 1);
        do_read(8'hC0, 8'h12, 1'b0);

        ev_q.push_back(mk_ev(1'b0, 10'h0, 8'h0, 16'h0, 1'b0, 1'b0, 6'h3F));
        do_write(8'hF2, 8'hFF, 1);
        ev_q.push_back(mk_ev(1'b0, 10'h0, 8'h0, 16'h0, 1'b1, 1'b0, 6'h0));
        do_write(8'hF0, 8'h00, 3);
        ev_q.push_back(mk_ev(1'b0, 10'h0, 8'h0, 16'h0, 1'b0, 1'b1, 6'h0));
        do_write(8'hF1, 8'h00, 1);

        do_write(8'h80, 8'h05, 1);
        ev_q.push_back(mk_ev(1'b0, 10'h0, 8'h0, 16'h0002, 1'b0, 1'b0, 6'h0));
        do_write(8'h91, 8'hEE, 1);
        do_read(8'h91, 8'hEE, 1'b0);

        // Reset lands on the same edge that would register the reset_opt pulse.
        addr    = 8'hF1;
        writeEn = 1'b1;
        reset   = 1'b1;
        @(posedge clk);
        #1 writeEn = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_read(8'h80, 8'h00, 1'b0);
        do_read(8'h91, 8'h05, 1'b0);
        do_read(8'h93, 8'h00, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("events_drained", ev_q.size(), 0);
        check("reads_drained", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
